// File: rtl/timer_pkg.sv
// Shared constants and helpers for the timer_wb bus-mapped timer/compare unit.
// Optional auto-reload on COMPARE0 is enabled by defining TIMER_AUTORELOAD_EN.
package timer_pkg;

    typedef logic [2:0] tmr_addr_t;

    localparam tmr_addr_t TMR_COUNT    = 3'd0;
    localparam tmr_addr_t TMR_CTRL     = 3'd1;
    localparam tmr_addr_t TMR_STATUS   = 3'd2;
    localparam tmr_addr_t TMR_PRESCALE = 3'd3;
    localparam tmr_addr_t TMR_COMPARE0 = 3'd4;

    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_IRQEN_LSB = 1;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    // Expands the byte-lane selects into a per-bit write mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/timer_prescale.sv
// Prescaler for timer_wb: counts while running and emits a tick when pcnt reaches PRESCALE.
module timer_prescale #(
    parameter int PWIDTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              clr_i,
    input  logic [PWIDTH-1:0] prescale_i,
    output logic              tick_o
);

    logic [PWIDTH-1:0] pcnt_q;
    logic [PWIDTH-1:0] pcnt_d;

    always_comb begin
        tick_o = run_i && (pcnt_q == prescale_i);
        pcnt_d = pcnt_q;
        if (clr_i || tick_o) begin
            pcnt_d = '0;
        end else if (run_i) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/timer_wb.sv
// Bus-mapped 32-bit timer with prescaler and NCHAN sticky compare channels driving irq_o.
// Defining TIMER_AUTORELOAD_EN makes COUNT reload to 0 when it would reach COMPARE0.
module timer_wb
    import timer_pkg::*;
#(
    parameter int NCHAN  = 3,
    parameter int PWIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [3:0]       sel_i,
    input  logic [2:0]       adr_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack_o,
    output logic [NCHAN-1:0] irq_o
);

    logic              ack_q;
    logic [31:0]       dat_q;
    logic [31:0]       count_q,  count_d;
    logic [NCHAN:0]    ctrl_q,   ctrl_d;
    logic [NCHAN-1:0]  pend_q,   pend_d;
    logic [PWIDTH-1:0] presc_q,  presc_d;
    logic [31:0]       cmp_q [NCHAN];
    logic [31:0]       cmp_d [NCHAN];

    logic              req;
    logic              wr_en;
    logic              count_wr;
    logic              presc_wr;
    logic              tick;
    logic [31:0]       lmask;
    logic [31:0]       count_inc;
    logic [31:0]       rdata;
    logic [NCHAN-1:0]  match;

    assign req       = cyc_i & stb_i;
    assign wr_en     = req & we_i & ack_q;
    assign lmask     = lane_mask(sel_i);
    assign count_wr  = wr_en && (adr_i == TMR_COUNT);
    assign presc_wr  = wr_en && (adr_i == TMR_PRESCALE);
    assign count_inc = count_q + 32'd1;

    timer_prescale #(
        .PWIDTH(PWIDTH)
    ) u_prescale (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .run_i      (ctrl_q[CTRL_RUN_BIT]),
        .clr_i      (count_wr | presc_wr),
        .prescale_i (presc_q),
        .tick_o     (tick)
    );

    // A bus write to COUNT overrides the tick, so no match is evaluated that cycle.
    always_comb begin
        match = '0;
        for (int n = 0; n < NCHAN; n++) begin
            match[n] = tick && !count_wr && (count_inc == cmp_q[n]);
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_wr) begin
            count_d = (count_q & ~lmask) | (dat_i & lmask);
        end else if (tick) begin
`ifdef TIMER_AUTORELOAD_EN
            count_d = (count_inc == cmp_q[0]) ? 32'd0 : count_inc;
`else
            count_d = count_inc;
`endif
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        pend_d  = pend_q;
        for (int n = 0; n < NCHAN; n++) begin
            cmp_d[n] = cmp_q[n];
        end

        if (wr_en && (adr_i == TMR_CTRL)) begin
            ctrl_d = (ctrl_q & ~lmask[NCHAN:0]) | (dat_i[NCHAN:0] & lmask[NCHAN:0]);
        end
        if (presc_wr) begin
            presc_d = (presc_q & ~lmask[PWIDTH-1:0]) | (dat_i[PWIDTH-1:0] & lmask[PWIDTH-1:0]);
        end
        if (wr_en && (adr_i == TMR_STATUS) && sel_i[0]) begin
            pend_d = pend_q & ~dat_i[NCHAN-1:0];
        end
        for (int n = 0; n < NCHAN; n++) begin
            if (wr_en && (adr_i == TMR_COMPARE0 + 3'(n))) begin
                cmp_d[n] = (cmp_q[n] & ~lmask) | (dat_i & lmask);
            end
        end

        // Applied after the clear so a coincident match keeps the flag set.
        pend_d = pend_d | match;
    end

    always_comb begin
        rdata = '0;
        case (adr_i)
            TMR_COUNT:    rdata = count_q;
            TMR_CTRL:     rdata[NCHAN:0] = ctrl_q;
            TMR_STATUS:   rdata[NCHAN-1:0] = pend_q;
            TMR_PRESCALE: rdata[PWIDTH-1:0] = presc_q;
            default: begin
                for (int n = 0; n < NCHAN; n++) begin
                    if (adr_i == TMR_COMPARE0 + 3'(n)) begin
                        rdata = cmp_q[n];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
            pend_q  <= '0;
            presc_q <= '0;
            for (int n = 0; n < NCHAN; n++) begin
                cmp_q[n] <= COMPARE_RESET;
            end
        end else begin
            ack_q   <= req & ~ack_q;
            dat_q   <= (req & ~ack_q) ? rdata : 32'd0;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
            for (int n = 0; n < NCHAN; n++) begin
                cmp_q[n] <= cmp_d[n];
            end
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign irq_o = pend_q & ctrl_q[NCHAN:CTRL_IRQEN_LSB];

endmodule

// File: tb/tb_timer_wb.sv
// Scoreboard bench for timer_wb: bus tasks queue expected read data, a negedge monitor checks each ack.
module tb_timer_wb;

    localparam int NCHAN  = 3;
    localparam int PWIDTH = 16;

    localparam logic [2:0] A_COUNT = 3'd0;
    localparam logic [2:0] A_CTRL  = 3'd1;
    localparam logic [2:0] A_STAT  = 3'd2;
    localparam logic [2:0] A_PRE   = 3'd3;
    localparam logic [2:0] A_CMP0  = 3'd4;
    localparam logic [2:0] A_CMP1  = 3'd5;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             cyc_i = 1'b0;
    logic             stb_i = 1'b0;
    logic             we_i  = 1'b0;
    logic [3:0]       sel_i = 4'h0;
    logic [2:0]       adr_i = 3'd0;
    logic [31:0]      dat_i = 32'd0;
    logic [31:0]      dat_o;
    logic             ack_o;
    logic [NCHAN-1:0] irq_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        string       name;
    } expEntry_t;

    expEntry_t expQ[$];
    expEntry_t monEntry;

    timer_wb #(
        .NCHAN  (NCHAN),
        .PWIDTH (PWIDTH)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .sel_i (sel_i),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .irq_o (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Every ack must match a queued access; reads also compare the returned data.
    always @(negedge clk_i) begin
        if (ack_o === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_ack: dat_o=%h with no access pending", dat_o);
            end else begin
                monEntry = expQ.pop_front();
                if (monEntry.chk && (dat_o !== monEntry.val)) begin
                    failures++;
                    $display("[TB] FAIL %s: got %h expected %h", monEntry.name, dat_o, monEntry.val);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic [31:0] expVal, input string name);
        expEntry_t e;
        int waited;
        logic got;
        e.chk  = ~we;
        e.val  = expVal;
        e.name = name;
        expQ.push_back(e);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = we;
        adr_i = adr;
        dat_i = dat;
        sel_i = sel;
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 8) begin
            @(posedge clk_i);
            #1;
            waited++;
            if (ack_o === 1'b1) got = 1'b1;
        end
        checkOutput({name, "_ack_latency"}, 32'(waited), 32'd1);
        if (got) begin
            @(posedge clk_i);
            #1;
        end
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        checkOutput({name, "_ack_pulse"}, {31'd0, ack_o}, 32'd0);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        applyStimulus(1'b1, adr, dat, sel, 32'd0, "write");
    endtask

    task automatic rd(input logic [2:0] adr, input logic [31:0] expVal, input string name);
        applyStimulus(1'b0, adr, 32'd0, 4'hF, expVal, name);
    endtask

    logic [31:0] resetTable [8];

    initial begin
        resetTable = '{32'd0, 32'd0, 32'd0, 32'd0,
                       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};

        #12;
        checkOutput("reset_ack", {31'd0, ack_o}, 32'd0);
        checkOutput("reset_dat", dat_o, 32'd0);
        checkOutput("reset_irq", 32'(irq_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        for (int a = 0; a < 8; a++) begin
            rd(3'(a), resetTable[a], $sformatf("reset_read_adr%0d", a));
        end

        // Prescale 3: COUNT steps every 4 cycles, channel 1 matches at 5.
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CMP1, 32'd5, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_i);
            #1;
            if (c == 19) checkOutput("irq1_before_match", 32'(irq_o), 32'h0);
            if (c == 20) checkOutput("irq1_at_match", 32'(irq_o), 32'h2);
        end
        wr(A_CTRL, 32'h4, 4'hF);
        rd(A_COUNT, 32'd5, "count_after_match");
        rd(A_STAT, 32'h2, "status_ch1_pending");

        wr(A_STAT, 32'h2, 4'h2);
        checkOutput("irq1_kept_lane1", 32'(irq_o), 32'h2);
        wr(A_STAT, 32'h2, 4'h1);
        checkOutput("irq1_cleared", 32'(irq_o), 32'h0);
        rd(A_STAT, 32'h0, "status_cleared");

        // Exactly two ticks from 0xFFFFFFFE: wraps to 0, channels 0 and 2 match at all-ones.
        wr(A_COUNT, 32'hFFFF_FFFE, 4'hF);
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_CTRL, 32'h0, 4'hF);
        rd(A_COUNT, 32'd0, "count_wrap");
        rd(A_STAT, 32'h5, "status_allones_match");
        wr(A_STAT, 32'h7, 4'h1);
        wr(A_COUNT, 32'hAABB_CCDD, 4'hF);
        wr(A_COUNT, 32'h0000_0012, 4'h1);
        rd(A_COUNT, 32'hAABB_CC12, "count_byte_lane");

        // STATUS clear lands on the tick that makes COUNT 10.
        wr(A_COUNT, 32'd8, 4'hF);
        wr(A_CMP1, 32'd10, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_STAT, 32'h2, 4'h1);
        wr(A_CTRL, 32'h0, 4'hF);
        rd(A_STAT, 32'h2, "set_wins_over_clear");
        rd(A_COUNT, 32'd12, "count_after_set_wins");

        // COUNT write lands on the tick that would have matched 0x21.
        wr(A_STAT, 32'h7, 4'h1);
        wr(A_COUNT, 32'h1F, 4'hF);
        wr(A_CMP1, 32'h21, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_COUNT, 32'h100, 4'hF);
        wr(A_CTRL, 32'h0, 4'hF);
        rd(A_COUNT, 32'h102, "count_write_wins");
        rd(A_STAT, 32'h0, "no_match_on_count_write");

        // Four ticks from 0 with COMPARE0 = 2.
        wr(A_STAT, 32'h7, 4'h1);
        wr(A_COUNT, 32'd0, 4'hF);
        wr(A_CMP0, 32'd2, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_CTRL, 32'h0, 4'hF);
`ifdef TIMER_AUTORELOAD_EN
        rd(A_COUNT, 32'd0, "count_autoreload");
`else
        rd(A_COUNT, 32'd4, "count_free_run");
`endif
        rd(A_STAT, 32'h1, "status_ch0_match");

        // Reset asserted during the wait state of a read.
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = A_COUNT;
        #3;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("midreset_no_ack", {31'd0, ack_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("midreset_no_ack2", {31'd0, ack_o}, 32'd0);
        checkOutput("midreset_dat", dat_o, 32'd0);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rd(A_CMP0, 32'hFFFF_FFFF, "cmp0_after_reset");
        rd(A_COUNT, 32'd0, "count_after_reset");
        rd(A_CTRL, 32'd0, "ctrl_after_reset");

        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
